// File: rtl/fire_control_if.sv
// Launcher-side engagement bus for the fire control sequencer.
// The master modport is the sequencer and the slave modport is the lock FSM, operator panel and launcher side.
interface fire_control_if;
  logic       lock_active;
  logic       operator_auth;
  logic       abort;
  logic       fire_ack;
  logic       fire_req;
  logic [3:0] rounds_fired;
  logic       engage_busy;
  logic       salvo_done;
  logic       fault;
  logic [2:0] state_dbg;

  modport master (
    input  lock_active, operator_auth, abort, fire_ack,
    output fire_req, rounds_fired, engage_busy, salvo_done, fault, state_dbg
  );

  modport slave (
    output lock_active, operator_auth, abort, fire_ack,
    input  fire_req, rounds_fired, engage_busy, salvo_done, fault, state_dbg
  );
endinterface

// File: rtl/fire_control_seq.sv
// Engagement sequencer: arms on a sustained lock, fires authorised rounds over a req/ack
// handshake with cooldown and salvo limit, and latches a fault on launcher timeout.
module fire_control_seq #(
  parameter logic [15:0] ARM_DELAY   = 16'd1000,
  parameter logic [15:0] COOLDOWN    = 16'd5000,
  parameter logic [15:0] ACK_TIMEOUT = 16'd20000,
  parameter logic [3:0]  SALVO_MAX   = 4'd4
) (
  input  logic              clk,
  input  logic              reset,
  fire_control_if.master    fc
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARMING   = 3'd1,
    S_READY    = 3'd2,
    S_FIRE     = 3'd3,
    S_COOLDOWN = 3'd4,
    S_DONE     = 3'd5,
    S_FAULT    = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q;
  logic [3:0]  rounds_q, rounds_d, rounds_inc;

  always_comb begin
    state_d    = state_q;
    rounds_d   = rounds_q;
    rounds_inc = rounds_q + 4'd1;
    case (state_q)
      S_IDLE: begin
        if (fc.lock_active && !fc.abort) begin
          state_d  = S_ARMING;
          rounds_d = 4'd0;
        end
      end
      S_ARMING: begin
        if (fc.abort || !fc.lock_active)    state_d = S_IDLE;
        else if (cnt_q == ARM_DELAY - 16'd1) state_d = S_READY;
      end
      S_READY: begin
        if (fc.abort || !fc.lock_active) state_d = S_IDLE;
        else if (fc.operator_auth)       state_d = S_FIRE;
      end
      // Lock loss is deliberately ignored here: the launcher may already be committed.
      S_FIRE: begin
        if (fc.fire_ack) begin
          rounds_d = rounds_inc;
          if (fc.abort)                    state_d = S_IDLE;
          else if (rounds_inc == SALVO_MAX) state_d = S_DONE;
          else                             state_d = S_COOLDOWN;
        end else if (fc.abort) begin
          state_d = S_IDLE;
        end else if (cnt_q == ACK_TIMEOUT - 16'd1) begin
          state_d = S_FAULT;
        end
      end
      S_COOLDOWN: begin
        if (fc.abort || !fc.lock_active) begin
          state_d = S_IDLE;
        end else if (cnt_q == COOLDOWN - 16'd1) begin
          state_d = fc.operator_auth ? S_FIRE : S_READY;
        end
      end
      S_DONE: begin
        if (fc.abort || !fc.lock_active) state_d = S_IDLE;
      end
      S_FAULT: begin
        if (fc.abort) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Phase counter restarts on every state change and saturates rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 16'd0;
      rounds_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      rounds_q <= rounds_d;
      if (state_d != state_q)    cnt_q <= 16'd0;
      else if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
    end
  end

  assign fc.fire_req     = (state_q == S_FIRE);
  assign fc.rounds_fired = rounds_q;
  assign fc.engage_busy  = (state_q == S_ARMING) || (state_q == S_READY) ||
                           (state_q == S_FIRE)   || (state_q == S_COOLDOWN);
  assign fc.salvo_done   = (state_q == S_DONE);
  assign fc.fault        = (state_q == S_FAULT);
  assign fc.state_dbg    = state_q;

endmodule

// File: tb/tb_fire_control_seq.sv
// Scoreboard bench for fire_control_seq: directed engagement scenarios plus a random soak,
// with expectations produced by a time-stamp based reference model of the engagement rules.
module tb_fire_control_seq;
  localparam int ARM   = 4;
  localparam int CD    = 3;
  localparam int TO    = 8;
  localparam int SALVO = 2;

  localparam int M_IDLE = 0, M_ARMING = 1, M_READY = 2, M_FIRE = 3;
  localparam int M_COOLDOWN = 4, M_DONE = 5, M_FAULT = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fire_control_if fc();

  fire_control_seq #(
    .ARM_DELAY  (16'(ARM)),
    .COOLDOWN   (16'(CD)),
    .ACK_TIMEOUT(16'(TO)),
    .SALVO_MAX  (4'(SALVO))
  ) dut (
    .clk  (clk),
    .reset(reset),
    .fc   (fc)
  );

  typedef struct {
    int st;
    int rounds;
    bit fr;
    bit busy;
    bit done;
    bit flt;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: the mode plus the edge index at which it was entered.
  int m_mode    = M_IDLE;
  int m_rounds  = 0;
  int m_entered = 0;
  int edge_n    = 0;

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_n, act, exp);
    end
  endtask

  task automatic model_step(input bit rst, input bit lock, input bit auth,
                            input bit ab, input bit ack);
    int age;
    int nxt;
    if (rst) begin
      m_mode    = M_IDLE;
      m_rounds  = 0;
      m_entered = edge_n;
      return;
    end
    age = edge_n - m_entered - 1;
    nxt = m_mode;
    if (m_mode == M_IDLE) begin
      if (lock && !ab) begin
        nxt      = M_ARMING;
        m_rounds = 0;
      end
    end else if (m_mode == M_ARMING) begin
      if (ab || !lock)        nxt = M_IDLE;
      else if (age == ARM - 1) nxt = M_READY;
    end else if (m_mode == M_READY) begin
      if (ab || !lock) nxt = M_IDLE;
      else if (auth)   nxt = M_FIRE;
    end else if (m_mode == M_FIRE) begin
      if (ack) begin
        m_rounds = m_rounds + 1;
        nxt = ab ? M_IDLE : ((m_rounds == SALVO) ? M_DONE : M_COOLDOWN);
      end else if (ab) begin
        nxt = M_IDLE;
      end else if (age == TO - 1) begin
        nxt = M_FAULT;
      end
    end else if (m_mode == M_COOLDOWN) begin
      if (ab || !lock)        nxt = M_IDLE;
      else if (age == CD - 1) nxt = auth ? M_FIRE : M_READY;
    end else if (m_mode == M_DONE) begin
      if (ab || !lock) nxt = M_IDLE;
    end else begin
      if (ab) nxt = M_IDLE;
    end
    if (nxt != m_mode) m_entered = edge_n;
    m_mode = nxt;
  endtask

  task automatic drive(input bit rst, input bit lock, input bit auth,
                       input bit ab, input bit ack);
    exp_t e;
    @(negedge clk);
    reset            = rst;
    fc.lock_active   = lock;
    fc.operator_auth = auth;
    fc.abort         = ab;
    fc.fire_ack      = ack;
    @(posedge clk);
    edge_n++;
    model_step(rst, lock, auth, ab, ack);
    e.st     = m_mode;
    e.rounds = m_rounds;
    e.fr     = (m_mode == M_FIRE);
    e.busy   = (m_mode >= M_ARMING) && (m_mode <= M_COOLDOWN);
    e.done   = (m_mode == M_DONE);
    e.flt    = (m_mode == M_FAULT);
    sb_q.push_back(e);
  endtask

  task automatic reach_fire();
    for (int i = 0; i < 20 && m_mode != M_FIRE; i++) drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic go_idle();
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: outputs are valid every cycle, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check_int("state_dbg",    int'(fc.state_dbg),    e.st);
        check_int("rounds_fired", int'(fc.rounds_fired), e.rounds);
        check_int("fire_req",     int'(fc.fire_req),     int'(e.fr));
        check_int("engage_busy",  int'(fc.engage_busy),  int'(e.busy));
        check_int("salvo_done",   int'(fc.salvo_done),   int'(e.done));
        check_int("fault",        int'(fc.fault),        int'(e.flt));
      end
    end
  end

  initial begin
    reset            = 1'b1;
    fc.lock_active   = 1'b0;
    fc.operator_auth = 1'b0;
    fc.abort         = 1'b0;
    fc.fire_ack      = 1'b0;

    // Reset held with inputs toggling
    for (int i = 0; i < 2; i++)
      drive(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Full salvo, ack one cycle after each request rise
    for (int i = 0; i < 40 && m_mode != M_DONE; i++)
      drive(1'b0, 1'b1, 1'b1, 1'b0, (m_mode == M_FIRE) && (edge_n - m_entered == 1));
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    go_idle();

    // Early lock loss during arming, then a full re-arm without authorisation
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    go_idle();

    // Launcher timeout, sticky fault, abort to clear
    reach_fire();
    for (int i = 0; i < 14; i++)
      drive(1'b0, 1'($urandom), 1'($urandom), 1'b0, (m_mode == M_FAULT) ? 1'($urandom) : 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    go_idle();

    // Abort coincident with ack
    reach_fire();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    go_idle();

    // Reset mid-fire, then a late ack
    reach_fire();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    go_idle();

    // Random soak
    for (int i = 0; i < 3000; i++)
      drive($urandom_range(0, 299) == 0, $urandom_range(0, 15) != 0,
            $urandom_range(0, 3) != 0,   $urandom_range(0, 47) == 0,
            $urandom_range(0, 3) == 0);
    go_idle();

    @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
